// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory responder
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_ERR_DATA = 32'h0;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, load extension and alignment/funct3 check
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Decode size from funct3: lane enables, replicated store data, extended load data
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    bad        = 1'b0;
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rbyte[7]}}, rbyte};
      end
      F3_BU: begin
        bad        = write;
        byte_en    = 4'b0001 << addr_lo;
        rdata_ext  = {24'h0, rbyte};
      end
      F3_H: begin
        bad        = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15]}}, rhalf};
      end
      F3_HU: begin
        bad        = write | addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        rdata_ext  = {16'h0, rhalf};
      end
      F3_W: begin
        bad        = (addr_lo != 2'b00);
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated load/store responder with internal word RAM
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_wdata;
  logic [31:0] ram [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [2:0]            acc_funct3;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_word;
  logic                  acc_oor;
  logic                  acc_err;
  logic [31:0]           rword;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_lane;
  logic [31:0]           rdata_ext;
  logic                  lane_bad;

  assign accept     = (state == ST_IDLE) && req_valid;
  assign enter_resp = (state_next == ST_RESP);

  // With zero wait states the access happens on the accept edge, before the latches hold the request
  assign acc_write  = (state == ST_IDLE) ? req_write  : lat_write;
  assign acc_addr   = (state == ST_IDLE) ? req_addr   : lat_addr;
  assign acc_funct3 = (state == ST_IDLE) ? req_funct3 : lat_funct3;
  assign acc_wdata  = (state == ST_IDLE) ? req_wdata  : lat_wdata;

  assign acc_word = acc_addr[ADDR_WIDTH+1:2];
  assign acc_oor  = |acc_addr[31:ADDR_WIDTH+2];
  assign acc_err  = acc_oor | lane_bad;
  assign rword    = ram[acc_word];

  mem_lane_align u_lane (
    .write      (acc_write),
    .funct3     (acc_funct3),
    .addr_lo    (acc_addr[1:0]),
    .wdata      (acc_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .bad        (lane_bad)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: IDLE accepts, WAIT counts down to 1, RESP always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid) state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd1) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs; stall drops in RESP so the response cycle releases the pipeline
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    stall      = req_valid && (state != ST_RESP);
  end

  // Request latches and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt   <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'h0;
      lat_funct3 <= 3'b000;
      lat_wdata  <= 32'h0;
    end else if (accept) begin
      wait_cnt   <= WAIT_INIT;
      lat_write  <= req_write;
      lat_addr   <= req_addr;
      lat_funct3 <= req_funct3;
      lat_wdata  <= req_wdata;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Response data registers on the edge that enters RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_err || acc_write) ? DMEM_ERR_DATA : rdata_ext;
    end
  end

  // RAM byte-lane write on the RESP-entry edge; contents survive reset
  always_ff @(posedge clk) begin
    if (enter_resp && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[acc_word][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench with behavioural memory model
module tb_data_mem_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 1 << 10;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] wd;
    int          cyc;
  } pend_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        z_valid = 1'b0, z_write = 1'b0;
  logic [31:0] z_addr = 32'h0, z_wdata = 32'h0;
  logic [2:0]  z_funct3 = 3'b000;
  logic        z_ready, z_resp_valid, z_err, z_stall;
  logic [31:0] z_rdata;

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          free_at = 0;
  pend_t       q[$];
  pend_t       np;
  logic [7:0]  mm [4*DEPTH];
  logic [31:0] last_rdata;
  logic        last_err;
  logic [2:0]  lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_write(z_write),
    .req_addr(z_addr), .req_funct3(z_funct3), .req_wdata(z_wdata),
    .req_ready(z_ready), .resp_valid(z_resp_valid), .resp_rdata(z_rdata),
    .resp_err(z_err), .stall(z_stall)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Little-endian byte memory; applies the access and returns what the responder must report
  function automatic void model_access(input pend_t p, output logic [31:0] d, output logic e);
    int sz, base;
    bit sx, legal;
    logic [31:0] v;
    sz = 4; sx = 0; legal = 1;
    case (p.f)
      3'd0: begin sz = 1; sx = 1; end
      3'd1: begin sz = 2; sx = 1; end
      3'd2: sz = 4;
      3'd4: begin sz = 1; legal = !p.w; end
      3'd5: begin sz = 2; legal = !p.w; end
      default: legal = 0;
    endcase
    e = !legal || ((p.a % sz) != 0) || (p.a >= 32'(4 * DEPTH));
    d = 32'h0;
    if (!e) begin
      base = int'(p.a);
      if (p.w) begin
        for (int i = 0; i < sz; i++) mm[base + i] = p.wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mm[base + i]) << (8 * i));
        if (sx && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        d = v;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset && req_valid && cyc >= free_at) begin
      np.w = req_write; np.a = req_addr; np.f = req_funct3; np.wd = req_wdata;
      np.cyc = cyc + WS + 1;
      q.push_back(np);
      free_at = cyc + WS + 2;
    end
    cyc++;
  end

  always @(negedge reset) begin
    q.delete();
    free_at = cyc;
  end

  always @(negedge clk) begin
    bit ev;
    logic [31:0] d;
    logic e;
    ev = (q.size() > 0) && (q[0].cyc == cyc);
    check("req_ready", 32'(req_ready), 32'(cyc >= free_at));
    check("resp_valid", 32'(resp_valid), 32'(ev));
    check("stall", 32'(stall), 32'(req_valid && !ev));
    if (!reset) begin
      check("reset_rdata", resp_rdata, 32'h0);
      check("reset_err", 32'(resp_err), 32'h0);
    end
    if (ev) begin
      model_access(q[0], d, e);
      check("resp_rdata", resp_rdata, d);
      check("resp_err", 32'(resp_err), 32'(e));
      last_rdata = resp_rdata;
      last_err = resp_err;
      void'(q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] wd, input bit keep);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f; req_wdata = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      idle(1);
      n++;
    end
    if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'h0);
  endtask

  task automatic req_pin(input string name, input bit w, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    last_rdata = 32'hBAD0_BAD0;
    last_err = 1'bx;
    issue(w, a, f, wd, 1'b0);
    drain();
    check({name, "_rdata"}, last_rdata, exp_d);
    check({name, "_err"}, 32'(last_err), 32'(exp_e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b1;
    idle(1);

    for (int i = 0; i < 32; i++) issue(1'b1, 32'(4 * i), 3'd2, $urandom, i < 31);
    drain();

    req_pin("sw_10", 1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 0);
    req_pin("lw_10", 0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 0);
    req_pin("lb_13", 0, 32'h13, 3'd0, 32'h0, 32'hFFFFFFDE, 0);
    req_pin("lbu_13", 0, 32'h13, 3'd4, 32'h0, 32'h000000DE, 0);
    req_pin("lh_12", 0, 32'h12, 3'd1, 32'h0, 32'hFFFFDEAD, 0);
    req_pin("lhu_10", 0, 32'h10, 3'd5, 32'h0, 32'h0000BEEF, 0);
    req_pin("sb_11", 1, 32'h11, 3'd0, 32'h55, 32'h0, 0);
    req_pin("lw_10b", 0, 32'h10, 3'd2, 32'h0, 32'hDEAD55EF, 0);
    req_pin("lw_12_mis", 0, 32'h12, 3'd2, 32'h0, 32'h0, 1);
    req_pin("sw_20", 1, 32'h20, 3'd2, 32'h11223344, 32'h0, 0);
    req_pin("sh_21_mis", 1, 32'h21, 3'd1, 32'hFFFF, 32'h0, 1);
    req_pin("lw_20", 0, 32'h20, 3'd2, 32'h0, 32'h11223344, 0);
    req_pin("oor_1000", 0, 32'h1000, 3'd2, 32'h0, 32'h0, 1);
    req_pin("f3_011", 0, 32'h10, 3'd3, 32'h0, 32'h0, 1);

    issue(0, 32'h10, 3'd2, 32'h0, 1'b1);
    issue(0, 32'h20, 3'd2, 32'h0, 1'b0);
    drain();

    req_pin("sw_40_zero", 1, 32'h40, 3'd2, 32'h0, 32'h0, 0);
    issue(1, 32'h40, 3'd2, 32'hCAFEF00D, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    idle(2);
    reset = 1'b1;
    idle(1);
    req_pin("lw_40", 0, 32'h40, 3'd2, 32'h0, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      bit w, keep;
      int r, r2;
      logic [2:0] f;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      f = (r < 8) ? lf[r % 5] : 3'($urandom_range(0, 7));
      r2 = $urandom_range(0, 15);
      if (r2 == 0) a = 32'h1000 | 32'($urandom_range(0, 255));
      else if (r2 == 1) a = $urandom;
      else a = 32'($urandom_range(0, 127));
      if (r2 >= 8) a = a & 32'hFFFF_FFFC;
      keep = (n < 59) && ($urandom_range(0, 2) == 0);
      issue(w, a, f, $urandom, keep);
      if (!keep) idle($urandom_range(0, 2));
    end
    drain();

    z_valid = 1'b1; z_write = 1'b1; z_addr = 32'h8; z_funct3 = 3'd2; z_wdata = 32'h12345678;
    @(negedge clk);
    check("z_ready_idle", 32'(z_ready), 32'h1);
    check("z_stall_idle", 32'(z_stall), 32'h1);
    check("z_valid_idle", 32'(z_resp_valid), 32'h0);
    @(posedge clk); #1;
    z_write = 1'b0;
    @(negedge clk);
    check("z_resp1_valid", 32'(z_resp_valid), 32'h1);
    check("z_resp1_ready", 32'(z_ready), 32'h0);
    check("z_resp1_stall", 32'(z_stall), 32'h0);
    check("z_resp1_err", 32'(z_err), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("z_acc2_ready", 32'(z_ready), 32'h1);
    check("z_acc2_valid", 32'(z_resp_valid), 32'h0);
    @(posedge clk); #1;
    z_valid = 1'b0;
    @(negedge clk);
    check("z_resp2_valid", 32'(z_resp_valid), 32'h1);
    check("z_resp2_rdata", z_rdata, 32'h12345678);
    check("z_resp2_err", 32'(z_err), 32'h0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
